// File: rtl/count_check_iw36_cw11_pkg.sv
// Shared definitions for the item-count checker: tracker state encoding
// and default widths. Optional feature macro: COUNT_CHECK_PASS_UNLOCKED_EN.
package count_check_iw36_cw11_pkg;

    localparam int DEF_DATA_WIDTH    = 36;
    localparam int DEF_CNT_WIDTH     = 11;
    localparam int DEF_ERR_CNT_WIDTH = 16;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

endpackage

// File: rtl/count_check_iw36_cw11_if.sv
// Item stream and status bundle of the count checker. The master drives the
// tagged input stream; the slave (the checker) drives the forwarded stream.
interface count_check_iw36_cw11_if
    import count_check_iw36_cw11_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
);
    logic                     valid_i;
    logic [CNT_WIDTH-1:0]     count_i;
    logic [DATA_WIDTH-1:0]    data_i;
    logic [CNT_WIDTH-1:0]     frame_len_i;
    logic                     valid_o;
    logic [DATA_WIDTH-1:0]    data_o;
    logic                     sof_o;
    logic                     eof_o;
    logic                     locked_o;
    logic                     err_o;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_o;

    modport master (
        output valid_i, count_i, data_i, frame_len_i,
        input  valid_o, data_o, sof_o, eof_o, locked_o, err_o, err_cnt_o
    );

    modport slave (
        input  valid_i, count_i, data_i, frame_len_i,
        output valid_o, data_o, sof_o, eof_o, locked_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/count_check_iw36_cw11_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module count_check_iw36_cw11_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q;

    // Count enabled events, holding once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && !(&cnt_q)) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/count_check_iw36_cw11.sv
// Item-count checker: locks on index 0, regenerates sof/eof against a
// programmable frame length, flags and counts index discontinuities.
// Optional feature macro: COUNT_CHECK_PASS_UNLOCKED_EN (forward items seen
// while unlocked with sof/eof cleared instead of dropping them).
module count_check_iw36_cw11
    import count_check_iw36_cw11_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
) (
    input logic                    clk,
    input logic                    sync_reset_n,
    count_check_iw36_cw11_if.slave bus
);
    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    exp_q, exp_d;
    logic [CNT_WIDTH-1:0]    last_q, last_d;
    logic                    valid_q, valid_d;
    logic                    sof_q, sof_d;
    logic                    eof_q, eof_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_WIDTH-1:0]    last_new;
    logic [CNT_WIDTH-1:0]    last_eff;

    // Index expected after cnt: wraps to 0 at the frame's last index.
    function automatic logic [CNT_WIDTH-1:0] next_exp(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [CNT_WIDTH-1:0] last
    );
        return (cnt == last) ? '0 : cnt + CNT_WIDTH'(1);
    endfunction

    // frame_len 0 wraps to all-ones, i.e. a full 2^CNT_WIDTH frame.
    assign last_new = bus.frame_len_i - CNT_WIDTH'(1);
    // An index-0 item opens a frame with the freshly latched length.
    assign last_eff = (bus.count_i == '0) ? last_new : last_q;

    // Tracker next-state and next-output decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        exp_d   = exp_q;
        last_d  = last_q;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        if (bus.valid_i) begin
            if (state_q == LOCKED && bus.count_i != '0 && bus.count_i != exp_q) begin
                // Mid-frame jump: unrecoverable until the next index 0.
                err_d   = 1'b1;
                state_d = UNLOCKED;
`ifdef COUNT_CHECK_PASS_UNLOCKED_EN
                valid_d = 1'b1;
                data_d  = bus.data_i;
`endif
            end else if (state_q == LOCKED || bus.count_i == '0) begin
                // In-sequence item, (re)lock on index 0, or truncated-frame resync.
                err_d   = (state_q == LOCKED) && (bus.count_i != exp_q);
                state_d = LOCKED;
                valid_d = 1'b1;
                data_d  = bus.data_i;
                sof_d   = (bus.count_i == '0);
                eof_d   = (bus.count_i == last_eff);
                exp_d   = next_exp(bus.count_i, last_eff);
                if (bus.count_i == '0) begin
                    last_d = last_new;
                end
            end else begin
                // Unlocked and not index 0: wait for a frame start.
`ifdef COUNT_CHECK_PASS_UNLOCKED_EN
                valid_d = 1'b1;
                data_d  = bus.data_i;
`endif
            end
        end
    end

    // Tracker state and registered outputs.
    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            state_q <= UNLOCKED;
            exp_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    count_check_iw36_cw11_sat_counter #(
        .WIDTH(ERR_CNT_WIDTH)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(sync_reset_n),
        .inc_i(err_d),
        .cnt_o(bus.err_cnt_o)
    );

    assign bus.valid_o  = valid_q;
    assign bus.data_o   = data_q;
    assign bus.sof_o    = sof_q;
    assign bus.eof_o    = eof_q;
    assign bus.err_o    = err_q;
    assign bus.locked_o = (state_q == LOCKED);
endmodule

// File: doc/count_check_iw36_cw11.md
Name: count_check_iw36_cw11

Overview:
Receive-side partner of the item-count tagger. Consumes a stream of 36-bit items, each tagged with an 11-bit running index, and checks index continuity against a programmable frame length. It locks on index 0 and regenerates frame markers (sof/eof). It drops items while unlocked, and flags and counts discontinuities. It sits downstream of the channelizer count stage, ahead of frame-aware consumers such as the FFT input buffer.

Parameters:
DATA_WIDTH, 36, item width
CNT_WIDTH, 11, index width
ERR_CNT_WIDTH, 16, width of the saturating error counter

Ports:
clk  in  1  clock
sync_reset_n  in  1  asynchronous active-low reset
valid_i  in  1  item strobe, no backpressure
count_i  in  CNT_WIDTH  index tagged on the item
data_i  in  DATA_WIDTH  item payload
frame_len_i  in  CNT_WIDTH  items per frame; 0 means 2^CNT_WIDTH
valid_o  out  1  output item strobe
data_o  out  DATA_WIDTH  forwarded payload
sof_o  out  1  qualified by valid_o: first item of frame (index 0)
eof_o  out  1  qualified by valid_o: last item of frame
locked_o  out  1  level; tracker is locked
err_o  out  1  single-cycle pulse on each discontinuity
err_cnt_o  out  ERR_CNT_WIDTH  saturating discontinuity count

Behaviour:
- Reset (async, sync_reset_n=0) clears all outputs and registers to 0:
  - state=UNLOCKED, exp=0, last=0, err_cnt=0.
- Latency: exactly 1 clk from an accepted valid_i to valid_o; all outputs registered.
- When valid_i=0: valid_o, sof_o, eof_o and err_o are 0 next cycle; state holds.
- Frame length latch: last = frame_len_i-1 (mod 2^CNT_WIDTH) is latched on every accepted index-0 item. It is constant for the rest of that frame.
- State UNLOCKED:
  - Item with count_i!=0: dropped (valid_o=0), no error.
  - Item with count_i==0: latch last, go LOCKED, forward the item with sof_o=1.
  - exp = 0 if last==0, else 1.
- State LOCKED, item accepted:
  - count_i==exp: forward the item.
    - sof_o=(count_i==0).
    - eof_o=(count_i==last).
    - exp = 0 if count_i==last, else count_i+1; wraps at 2^CNT_WIDTH.
  - count_i!=exp and count_i==0 (truncated frame, resync):
    - err_o=1, err_cnt++.
    - Latch last, forward with sof_o=1, stay LOCKED, exp updated as above.
  - count_i!=exp and count_i!=0:
    - err_o=1, err_cnt++, item dropped, go UNLOCKED.
- frame_len_i=1 (last=0): every item is both sof and eof; exp stays 0.
- frame_len_i=0: last=2047, full-range wrap.
- err_cnt saturates at all-ones and never wraps.
- locked_o = (state==LOCKED), registered.
- Reset asserted mid-frame: immediate clear. The first item after release must be index 0 to lock.

Optional Feature:
COUNT_CHECK_PASS_UNLOCKED_EN:
- Defined: items received while UNLOCKED, including the one that caused the unlock, are forwarded with valid_o=1, sof_o=0, eof_o=0. err_o and err_cnt behave identically.
- Undefined: those items are dropped as specified above.

Decomposition:
- Shared package holds:
  - state encoding (UNLOCKED=1'b0, LOCKED=1'b1)
  - CNT_WIDTH, DATA_WIDTH and ERR_CNT_WIDTH defaults
- One natural sub-module: sat_counter (saturating ERR_CNT_WIDTH incrementer with enable).
- Tracker FSM and output register stay in the top module.

Test Plan:
1. Reset release, frame_len_i=4, indices 0,1,2,3,0,1,2,3 with valid_i=1 every cycle:
   - valid_o follows 1 cycle later.
   - sof_o on the 1st and 5th items, eof_o on the 4th and 8th.
   - locked_o=1 from cycle 2; err_cnt_o=0.
2. Unlocked start, indices 5,6,0,1:
   - first two dropped, no error.
   - item "0" is forwarded with sof_o=1.
3. Locked with frame_len_i=8, indices 0,1,2,5,6,0:
   - err_o pulses once at "5", err_cnt_o=1.
   - "5" and "6" dropped.
   - relock at "0" with sof_o=1.
4. Truncation, frame_len_i=8, indices 0,1,2,0:
   - err_o at the second "0", err_cnt_o=1.
   - item forwarded with sof_o=1; locked_o stays 1.
5. Boundaries:
   - frame_len_i=1: stream of zeros gives sof_o=eof_o=1 on every item.
   - frame_len_i=0: indices 0..2047,0 give eof_o at 2047, no error.
   - Forcing ERR_CNT_WIDTH=2 and causing 5 errors gives err_cnt_o=3.
6. Reset mid-frame at index 3, then indices 4,0:
   - outputs clear asynchronously.
   - "4" dropped, "0" locks.
   - With COUNT_CHECK_PASS_UNLOCKED_EN defined, "4" is forwarded with sof_o=eof_o=0.
